// File: rtl/rf_pkg.sv
// Shared definitions for the register-file command sequencer.
// Contents: operation encodings, register-function (FunSel) codes,
// register index constants, sequencer FSM states and two small helpers
// (request legality check and op -> FunSel mapping).
package rf_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_CLR  = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4,
        OP_MOVE = 3'd5,
        OP_SWAP = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    localparam logic [2:0] IDX_R1 = 3'd0;
    localparam logic [2:0] IDX_R2 = 3'd1;
    localparam logic [2:0] IDX_R3 = 3'd2;
    localparam logic [2:0] IDX_R4 = 3'd3;
    localparam logic [2:0] IDX_S1 = 3'd4;
    localparam logic [2:0] IDX_S2 = 3'd5;
    localparam logic [2:0] IDX_S3 = 3'd6;
    localparam logic [2:0] IDX_S4 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP1 = 2'd1,
        ST_STEP2 = 2'd2,
        ST_STEP3 = 2'd3
    } state_e;

    // A SWAP must not touch its own temporary and must name two different
    // registers, otherwise the three-step exchange would corrupt data.
    function automatic logic is_illegal(input op_e op, input logic [2:0] dst,
                                        input logic [2:0] src, input logic [2:0] temp);
        return (op == OP_RSVD) ||
               ((op == OP_SWAP) && ((dst == src) || (dst == temp) || (src == temp)));
    endfunction

    // MOVE and SWAP are built from LOAD steps fed by the OutA read port.
    function automatic logic [2:0] op_fun(input op_e op);
        case (op)
            OP_CLR:  return FUN_CLR;
            OP_INC:  return FUN_INC;
            OP_DEC:  return FUN_DEC;
            default: return FUN_LOAD;
        endcase
    endfunction

endpackage

// File: rtl/rf_sequencer_if.sv
// Request / register-file bundle for rf_sequencer.
// Handshake: a request transfers on a rising clock edge where ReqValid and
// ReqReady are both 1; the requester keeps Op/Dst/Src/Din stable and
// ReqValid high until that edge, and ReqReady never depends on ReqValid.
// master: decoder + register-file side (drives requests and RfOutA).
// slave : the sequencer (drives ReqReady, step controls, status, dbg_state).
interface rf_sequencer_if
    import rf_pkg::*;
#(
    parameter int WIDTH = 16
) ();
    logic             ReqValid;
    logic             ReqReady;
    logic [2:0]       Op;
    logic [2:0]       Dst;
    logic [2:0]       Src;
    logic [WIDTH-1:0] Din;
    logic [WIDTH-1:0] RfOutA;
    logic [WIDTH-1:0] RfI;
    logic [3:0]       RegSel;
    logic [3:0]       ScrSel;
    logic [2:0]       FunSel;
    logic [2:0]       OutASel;
    logic [2:0]       OutBSel;
    logic             Busy;
    logic             Done;
    logic             Err;
    state_e           dbg_state;

    modport master (
        output ReqValid, Op, Dst, Src, Din, RfOutA,
        input  ReqReady, RfI, RegSel, ScrSel, FunSel, OutASel, OutBSel,
               Busy, Done, Err, dbg_state
    );

    modport slave (
        input  ReqValid, Op, Dst, Src, Din, RfOutA,
        output ReqReady, RfI, RegSel, ScrSel, FunSel, OutASel, OutBSel,
               Busy, Done, Err, dbg_state
    );
endinterface

// File: rtl/rf_sel_decode.sv
// Register index -> active-low one-hot write enables.
// Ports: idx (0-3 = R1-R4, 4-7 = S1-S4), en (step active),
//        reg_sel / scr_sel (bit3 = R1/S1 ... bit0 = R4/S4, low = write).
module rf_sel_decode (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [3:0] reg_sel,
    output logic [3:0] scr_sel
);
    logic [3:0] onehot;

    always_comb begin
        onehot  = 4'b1000 >> idx[1:0];
        reg_sel = 4'b1111;
        scr_sel = 4'b1111;
        if (en) begin
            if (idx[2]) scr_sel = ~onehot;
            else        reg_sel = ~onehot;
        end
    end
endmodule

// File: rtl/rf_sequencer.sv
// Command-side controller for the 8-entry register file.
// Accepts one register operation per handshake and expands it into one
// (LOAD/CLR/INC/DEC/MOVE) or three (SWAP via TEMP_IDX) registered steps.
// Ports: Clock, Reset (async, active-low), bus (rf_sequencer_if.slave):
//   request side ReqValid/ReqReady/Op/Dst/Src/Din, register-file side
//   RfOutA/RfI/RegSel/ScrSel/FunSel/OutASel/OutBSel, status Busy/Done/Err,
//   and dbg_state (current FSM state).
module rf_sequencer
    import rf_pkg::*;
#(
    parameter int         WIDTH    = 16,
    parameter logic [2:0] TEMP_IDX = 3'd7
) (
    input  logic          Clock,
    input  logic          Reset,
    rf_sequencer_if.slave bus
);
    state_e           state_q, state_d;
    op_e              op_q, op_d, op_in;
    logic [2:0]       dst_q, dst_d, src_q, src_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [2:0]       fun_q, fun_d, outa_q, outa_d, outb_q, outb_d;
    logic [3:0]       reg_sel_q, reg_sel_d, scr_sel_q, scr_sel_d;
    logic             done_q, done_d, err_q, err_d;
    logic             step_en_d;
    logic [2:0]       step_idx_d;
    logic             accept;

    assign op_in  = op_e'(bus.Op);
    // Held low during reset so nothing is offered before release.
    assign bus.ReqReady = (state_q == ST_IDLE) && Reset;
    assign accept       = bus.ReqValid && bus.ReqReady;

    // Step controls are computed for the cycle that follows the edge and
    // registered, so every step output comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        dst_d      = dst_q;
        src_d      = src_q;
        din_d      = din_q;
        fun_d      = fun_q;
        outa_d     = outa_q;
        outb_d     = outb_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        step_en_d  = 1'b0;
        step_idx_d = dst_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = op_in;
                    dst_d = bus.Dst;
                    src_d = bus.Src;
                    din_d = bus.Din;
                    if (is_illegal(op_in, bus.Dst, bus.Src, TEMP_IDX)) begin
                        err_d = 1'b1;
                    end else if (op_in != OP_NOP) begin
                        state_d   = ST_STEP1;
                        step_en_d = 1'b1;
                        fun_d     = op_fun(op_in);
                        outb_d    = bus.Src;
                        if (op_in == OP_SWAP) begin
                            // Park the old Dst value in the temporary first.
                            step_idx_d = TEMP_IDX;
                            outa_d     = bus.Dst;
                        end else begin
                            step_idx_d = bus.Dst;
                            done_d     = 1'b1;
                            if (op_in == OP_MOVE) outa_d = bus.Src;
                        end
                    end
                end
            end
            ST_STEP1: begin
                if (op_q == OP_SWAP) begin
                    state_d    = ST_STEP2;
                    step_en_d  = 1'b1;
                    step_idx_d = dst_q;
                    fun_d      = FUN_LOAD;
                    outa_d     = src_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP2: begin
                state_d    = ST_STEP3;
                step_en_d  = 1'b1;
                step_idx_d = src_q;
                fun_d      = FUN_LOAD;
                outa_d     = TEMP_IDX;
                done_d     = 1'b1;
            end
            ST_STEP3: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    rf_sel_decode u_sel_decode (
        .idx     (step_idx_d),
        .en      (step_en_d),
        .reg_sel (reg_sel_d),
        .scr_sel (scr_sel_d)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            dst_q     <= 3'd0;
            src_q     <= 3'd0;
            din_q     <= '0;
            fun_q     <= FUN_LOAD;
            outa_q    <= 3'd0;
            outb_q    <= 3'd0;
            reg_sel_q <= 4'b1111;
            scr_sel_q <= 4'b1111;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dst_q     <= dst_d;
            src_q     <= src_d;
            din_q     <= din_d;
            fun_q     <= fun_d;
            outa_q    <= outa_d;
            outb_q    <= outb_d;
            reg_sel_q <= reg_sel_d;
            scr_sel_q <= scr_sel_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // MOVE/SWAP data is whatever the selected OutA port presents this cycle.
    assign bus.RfI       = (op_q == OP_LOAD) ? din_q : bus.RfOutA;
    assign bus.RegSel    = reg_sel_q;
    assign bus.ScrSel    = scr_sel_q;
    assign bus.FunSel    = fun_q;
    assign bus.OutASel   = outa_q;
    assign bus.OutBSel   = outb_q;
    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.Done      = done_q;
    assign bus.Err       = err_q;
    assign bus.dbg_state = state_q;
endmodule

// File: doc/rf_sequencer.md
Name: rf_sequencer

Overview:
- Command-side controller for the 8-entry register file (R1–R4, S1–S4).
- Accepts one register operation per valid/ready handshake and expands it into one or three register-file steps. Each step drives RegSel/ScrSel/FunSel/OutASel/OutBSel and the register-file data input.
- Sits between the instruction decoder and the register file. Makes MOVE and SWAP (through a scratch temp) single requests for the decoder.

Parameters:
- WIDTH, 16, data path width of Din/RfOutA/RfI.
- TEMP_IDX, 7, register index used as the SWAP temporary (7 = S4).

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  sequencer can accept; equals 1 exactly when state is IDLE
- Op  in  3  operation (encoding in package)
- Dst  in  3  destination index; 0–3 = R1–R4, 4–7 = S1–S4
- Src  in  3  source index, same encoding
- Din  in  WIDTH  immediate for LOAD
- RfOutA  in  WIDTH  register file OutA, fed back for MOVE/SWAP
- RfI  out  WIDTH  register file data input
- RegSel  out  4  R enables, active-low; bit3 = R1 … bit0 = R4
- ScrSel  out  4  S enables, active-low; bit3 = S1 … bit0 = S4
- FunSel  out  3  register function
- OutASel  out  3  register file A read select
- OutBSel  out  3  register file B read select
- Busy  out  1  a step sequence is in progress
- Done  out  1  one-cycle pulse on the final step of an operation
- Err  out  1  one-cycle pulse when an illegal request is accepted

Behaviour:
- Reset (async, Reset=0):
  - state = IDLE; RegSel = ScrSel = 4'b1111; FunSel = LOAD; OutASel = OutBSel = 0.
  - Din latch = 0; Busy = Done = Err = 0; ReqReady = 1 once Reset is released.
  - Reset in mid-sequence abandons the operation. Registers already written stay written; no Done is produced.
- Acceptance: at a rising edge with ReqValid=1 and ReqReady=1.
  - Op, Dst and Src are captured. Din is captured into a latch.
  - ReqValid while ReqReady=0 is ignored; the requester holds the request.
- Step outputs are registered.
  - Accept at edge k: step 1 is driven during cycle k+1, and each further step takes one more cycle.
  - Outside steps: RegSel = ScrSel = 4'b1111, and FunSel/OutASel/OutBSel hold their last values.
  - Exactly one enable bit is low during a step.
- RfI: Din latch for LOAD; RfOutA (combinational pass-through) for MOVE/SWAP steps.
- Ops, each step listed as enable target / FunSel / OutASel; OutBSel = Src during every step:
  - NOP (000): no step. No Done; returns to IDLE next cycle.
  - LOAD (001): Dst / LOAD / -.
  - CLR (010): Dst / CLR / -.
  - INC (011): Dst / INC / -.
  - DEC (100): Dst / DEC / -.
  - MOVE (101): Dst / LOAD / Src. MOVE with Src==Dst is legal (reloads itself).
  - SWAP (110), three steps:
    - step 1: TEMP_IDX / LOAD / Dst.
    - step 2: Dst / LOAD / Src.
    - step 3: Src / LOAD / TEMP_IDX.
  - 111: reserved.
- Illegal requests: Op 111, SWAP with Src==Dst, or SWAP with Src or Dst == TEMP_IDX.
  - They are accepted, produce no step and pulse Err in cycle k+1. Done stays 0.
- FSM: IDLE → STEP1 → (single-step ops) IDLE; SWAP: STEP1 → STEP2 → STEP3 → IDLE.
- Busy = 1 in the STEP states. Done = 1 in the final step cycle.
- Throughput:
  - Single-step op: ReqReady returns at cycle k+2, so one op per 2 cycles.
  - SWAP: one op per 4 cycles.
- INC/DEC wrap-around is handled by the register itself. The sequencer issues the function only.

Decomposition:
- Shared package rf_pkg:
  - Op encodings: NOP, LOAD, CLR, INC, DEC, MOVE, SWAP.
  - FunSel constants: DEC = 3'b000, INC = 3'b001, LOAD = 3'b010, CLR = 3'b011.
  - Register index constants R1 … S4.
  - FSM state enum.
- Sub-module rf_sel_decode: combinational; 3-bit index + enable flag → {RegSel, ScrSel}, active-low one-hot, 4'b1111/4'b1111 when not enabled.

Test Plan:
- Reset held low with ReqValid=1 → RegSel = ScrSel = 4'b1111, Busy = 0, ReqReady = 0 until release, then 1; no write strobe.
- LOAD Dst=2, Din=16'hBEEF → cycle k+1: RegSel = 4'b1101, ScrSel = 4'b1111, FunSel = 3'b010, RfI = 16'hBEEF, Done = 1; R3 reads 16'hBEEF afterwards.
- MOVE Src=0 (R1 = 16'h1234), Dst=5 → OutASel = 0, ScrSel = 4'b1011, RfI = 16'h1234; S2 reads 16'h1234.
- SWAP Dst=1 (16'h00AA), Src=4 (16'h5500):
  - → three consecutive steps with Busy = 1 and ReqReady = 0.
  - Done only in step 3.
  - R2 = 16'h5500, S1 = 16'h00AA, S4 = 16'h00AA.
- Illegal requests (SWAP Dst=Src=3; SWAP Src=7; Op=111) → Err pulse at k+1, no enable low, Done = 0, ReqReady = 1 at k+2.
- Reset asserted in SWAP step 2 → enables immediately 4'b1111/4'b1111, state IDLE, no Done; back-to-back INC,INC on R4 = 16'hFFFF → 16'h0001.
